// File: rtl/mem_access_ctrl.sv
// Single-access sequencer between the CPU MAR/MDR and a single-port RAM with
// registered read data; checks the MAR range and pulses done once per request.
module mem_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req,
  input  logic              wr,
  input  logic [31:0]       mar_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] wait_cnt;
  logic       wr_p0;
  logic       addr_oor;
  logic       accept;

  assign addr_oor = |mar_in[31:ADDR_W];
  assign accept   = (state == S_IDLE) && req;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req) state_nxt = addr_oor ? S_DONE : S_ACCESS;
      S_ACCESS: begin
        if (WAIT_STATES > 0) state_nxt = S_WAIT;
        else                 state_nxt = wr_p0 ? S_DONE : S_CAPTURE;
      end
      S_WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = wr_p0 ? S_DONE : S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request capture: address, write data and direction held until the next accept
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      wr_p0       <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      mdr_out     <= '0;
      addr_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ram_address <= mar_in[ADDR_W-1:0];
        ram_data_in <= wdata_in;
        wr_p0       <= wr;
        addr_err    <= addr_oor;
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + 4'd1;
      else                 wait_cnt <= 4'd0;
      // RAM read data has been registered since the ACCESS exit edge
      if (state == S_CAPTURE) mdr_out <= ram_data_out;
    end
  end

  // Enables qualified by clr_n so a reset edge never commits a RAM access
  assign ram_we = clr_n && (state == S_ACCESS) && wr_p0;
  assign ram_re = clr_n && (state == S_ACCESS) && !wr_p0;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one DUT with no wait states and one with
// two, each attached to a small registered-read RAM model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        preload;
  logic        req0, req2, wr;
  logic [31:0] mar_in, wdata_in;

  logic [7:0]  addr0, addr2;
  logic [31:0] din0, din2, rdata0, rdata2, mdr0, mdr2;
  logic        we0, re0, busy0, done0, err0;
  logic        we2, re2, busy2, done2, err2;

  logic [31:0] mem0 [256];
  logic [31:0] mem2 [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .clr_n(clr_n), .req(req0), .wr(wr), .mar_in(mar_in),
    .wdata_in(wdata_in), .ram_data_out(rdata0), .ram_address(addr0),
    .ram_data_in(din0), .ram_we(we0), .ram_re(re0), .mdr_out(mdr0),
    .busy(busy0), .done(done0), .addr_err(err0));

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) u2 (
    .clk(clk), .clr_n(clr_n), .req(req2), .wr(wr), .mar_in(mar_in),
    .wdata_in(wdata_in), .ram_data_out(rdata2), .ram_address(addr2),
    .ram_data_in(din2), .ram_we(we2), .ram_re(re2), .mdr_out(mdr2),
    .busy(busy2), .done(done2), .addr_err(err2));

  always @(posedge clk) begin
    if (preload) begin
      mem0[8'h54] <= 32'h97;
      mem0[8'h34] <= 32'h25;
      mem0[8'h68] <= 32'h11;
      mem2[8'h54] <= 32'h97;
    end else begin
      if (we0) mem0[addr0] <= din0;
      if (re0) rdata0 <= mem0[addr0];
      if (we2) mem2[addr2] <= din2;
      if (re2) rdata2 <= mem2[addr2];
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // {ram_re, ram_we, busy, done}
  task automatic test_reset;
    clr_n = 1'b0; preload = 1'b1; req0 = 0; req2 = 0; wr = 0;
    mar_in = 0; wdata_in = 0;
    @(negedge clk); step; step;
    n_checks++;
    if ({re0, we0, busy0, done0, err0, addr0, din0, mdr0} !== '0) begin
      n_errors++;
      $display("FAIL reset_u0: got re/we/busy/done/err=%b%b%b%b%b addr=%h din=%h mdr=%h required all 0",
               re0, we0, busy0, done0, err0, addr0, din0, mdr0);
    end
    n_checks++;
    if ({re2, we2, busy2, done2, err2, addr2, din2, mdr2} !== '0) begin
      n_errors++;
      $display("FAIL reset_u2: got nonzero outputs mdr=%h addr=%h required all 0", mdr2, addr2);
    end
    clr_n = 1'b1; preload = 1'b0;
    step;
  endtask

  task automatic test_read;
    req0 = 1; wr = 0; mar_in = 32'h54;
    step; req0 = 0;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b1010) begin
      n_errors++; $display("FAIL read_access: got %b required 1010", {re0, we0, busy0, done0});
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0010) begin
      n_errors++; $display("FAIL read_capture: got %b required 0010", {re0, we0, busy0, done0});
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0011 || mdr0 !== 32'h97) begin
      n_errors++; $display("FAIL read_done: got %b mdr=%h required 0011 mdr=00000097",
                           {re0, we0, busy0, done0}, mdr0);
    end
    step;
    n_checks++;
    if ({busy0, done0} !== 2'b00 || mdr0 !== 32'h97) begin
      n_errors++; $display("FAIL read_idle: got busy/done=%b mdr=%h required 00 mdr=00000097",
                           {busy0, done0}, mdr0);
    end
  endtask

  task automatic test_write_read;
    req0 = 1; wr = 1; mar_in = 32'h52; wdata_in = 32'h2F;
    step; req0 = 0;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0110 || addr0 !== 8'h52 || din0 !== 32'h2F) begin
      n_errors++; $display("FAIL write_access: got %b addr=%h din=%h required 0110 addr=52 din=2f",
                           {re0, we0, busy0, done0}, addr0, din0);
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0011 || mem0[8'h52] !== 32'h2F || addr0 !== 8'h52) begin
      n_errors++; $display("FAIL write_done: got %b ram[52]=%h addr=%h required 0011 ram[52]=2f addr=52",
                           {re0, we0, busy0, done0}, mem0[8'h52], addr0);
    end
    step;
    req0 = 1; wr = 0; wdata_in = 32'hFFFF_FFFF;
    step; req0 = 0;
    step; step;
    n_checks++;
    if (done0 !== 1'b1 || mdr0 !== 32'h2F) begin
      n_errors++; $display("FAIL readback: got done=%b mdr=%h required done=1 mdr=0000002f", done0, mdr0);
    end
    step;
  endtask

  task automatic test_addr_err;
    req0 = 1; wr = 0; mar_in = 32'h12C;
    step; req0 = 0;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0011 || err0 !== 1'b1 || mdr0 !== 32'h2F) begin
      n_errors++; $display("FAIL addr_err_done: got %b err=%b mdr=%h required 0011 err=1 mdr=0000002f",
                           {re0, we0, busy0, done0}, err0, mdr0);
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0000 || err0 !== 1'b1) begin
      n_errors++; $display("FAIL addr_err_hold: got %b err=%b required 0000 err=1",
                           {re0, we0, busy0, done0}, err0);
    end
  endtask

  task automatic test_ignore_busy;
    req0 = 1; wr = 0; mar_in = 32'h34;
    step;
    mar_in = 32'h10;
    n_checks++;
    if (re0 !== 1'b1 || err0 !== 1'b0 || addr0 !== 8'h34) begin
      n_errors++; $display("FAIL busy_access: got re=%b err=%b addr=%h required re=1 err=0 addr=34",
                           re0, err0, addr0);
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0010 || addr0 !== 8'h34) begin
      n_errors++; $display("FAIL busy_capture: got %b addr=%h required 0010 addr=34",
                           {re0, we0, busy0, done0}, addr0);
    end
    step;
    n_checks++;
    if ({re0, we0, busy0, done0} !== 4'b0011 || mdr0 !== 32'h25) begin
      n_errors++; $display("FAIL busy_done: got %b mdr=%h required 0011 mdr=00000025",
                           {re0, we0, busy0, done0}, mdr0);
    end
    step; req0 = 0;
    n_checks++;
    if ({re0, we0, busy0} !== 3'b000 || addr0 !== 8'h34) begin
      n_errors++; $display("FAIL busy_idle: got re/we/busy=%b addr=%h required 000 addr=34",
                           {re0, we0, busy0}, addr0);
    end
    step;
    n_checks++;
    if ({re0, we0, busy0} !== 3'b000 || mdr0 !== 32'h25) begin
      n_errors++; $display("FAIL busy_no_requeue: got %b mdr=%h required 000 mdr=00000025",
                           {re0, we0, busy0}, mdr0);
    end
  endtask

  task automatic test_back_to_back;
    req0 = 1; wr = 0; mar_in = 32'h54;
    step; step; step; step;
    n_checks++;
    if ({re0, busy0, done0} !== 3'b000) begin
      n_errors++; $display("FAIL b2b_idle_gap: got re/busy/done=%b required 000", {re0, busy0, done0});
    end
    step; req0 = 0;
    n_checks++;
    if ({re0, busy0} !== 2'b11) begin
      n_errors++; $display("FAIL b2b_reaccept: got re/busy=%b required 11", {re0, busy0});
    end
    step; step;
    n_checks++;
    if (done0 !== 1'b1 || mdr0 !== 32'h97) begin
      n_errors++; $display("FAIL b2b_done: got done=%b mdr=%h required done=1 mdr=00000097", done0, mdr0);
    end
    step;
  endtask

  task automatic test_reset_mid_write;
    req0 = 1; wr = 1; mar_in = 32'h68; wdata_in = 32'hAB;
    step; req0 = 0;
    n_checks++;
    if (we0 !== 1'b1) begin
      n_errors++; $display("FAIL rst_pre_we: got we=%b required 1", we0);
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (we0 !== 1'b0) begin
      n_errors++; $display("FAIL rst_we_gated: got we=%b required 0", we0);
    end
    @(negedge clk);
    clr_n = 1'b1;
    n_checks++;
    if ({re0, we0, busy0, done0, err0} !== 5'b0 || addr0 !== 8'h0 || din0 !== 32'h0 || mdr0 !== 32'h0) begin
      n_errors++; $display("FAIL rst_outputs: got %b addr=%h din=%h mdr=%h required all 0",
                           {re0, we0, busy0, done0, err0}, addr0, din0, mdr0);
    end
    n_checks++;
    if (mem0[8'h68] !== 32'h11) begin
      n_errors++; $display("FAIL rst_no_commit: got ram[68]=%h required 00000011", mem0[8'h68]);
    end
    step;
  endtask

  task automatic test_wait_states;
    logic [3:0] pat;
    req2 = 1; wr = 0; mar_in = 32'h54;
    step; req2 = 0;
    n_checks++;
    if ({re2, we2, busy2, done2} !== 4'b1010) begin
      n_errors++; $display("FAIL ws_access: got %b required 1010", {re2, we2, busy2, done2});
    end
    for (int c = 1; c <= 3; c++) begin
      step;
      pat = {re2, we2, busy2, done2};
      n_checks++;
      if (pat !== 4'b0010) begin
        n_errors++; $display("FAIL ws_cycle%0d: got %b required 0010", c, pat);
      end
    end
    step;
    n_checks++;
    if ({re2, we2, busy2, done2} !== 4'b0011 || mdr2 !== 32'h97) begin
      n_errors++; $display("FAIL ws_done: got %b mdr=%h required 0011 mdr=00000097",
                           {re2, we2, busy2, done2}, mdr2);
    end
    step;
    n_checks++;
    if ({busy2, done2} !== 2'b00) begin
      n_errors++; $display("FAIL ws_idle: got busy/done=%b required 00", {busy2, done2});
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_read;
    test_addr_err;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid_write;
    test_wait_states;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
